// File: rtl/ps2_pkg.sv
// Purpose: shared types and constants for the PS/2 set-2 keyboard decoder.
// Latency: n/a (package only).
// Backpressure: n/a.
package ps2_pkg;

  // Prefix state machine for set-2 scancode sequences
  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } pfx_state_t;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_BKSP   = 8'h66;

  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  // The receiver delivers the byte LSB-first in cmd[8:1], so cmd[8] is bit 0.
  function automatic logic [7:0] bitrev8(input logic [7:0] d);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[7-i];
    return r;
  endfunction

  function automatic logic is_modifier(input logic [7:0] sc);
    return (sc == SC_LSHIFT) || (sc == SC_RSHIFT) || (sc == SC_CAPS);
  endfunction

endpackage

// File: rtl/ps2_scan2ascii.sv
// Purpose: set-2 make code to ASCII translation (letters, digit row, space/enter/backspace).
// Latency: combinational, zero cycles.
// Backpressure: none; valid=0 for codes that produce no character.
// Ports: sc (code byte), extended (E0-prefixed), shift_xor_caps (letter case select),
//        shift_held (digit-row symbol select), ascii (character), valid (character exists).
module ps2_scan2ascii
  import ps2_pkg::*;
(
  input  logic [7:0] sc,
  input  logic       extended,
  input  logic       shift_xor_caps,
  input  logic       shift_held,
  output logic [7:0] ascii,
  output logic       valid
);

  logic [4:0] letter_idx;
  logic       is_letter;

  always_comb begin
    ascii      = 8'h00;
    valid      = 1'b0;
    is_letter  = 1'b1;
    letter_idx = 5'd0;
    case (sc)
      8'h1C: letter_idx = 5'd0;   8'h32: letter_idx = 5'd1;
      8'h21: letter_idx = 5'd2;   8'h23: letter_idx = 5'd3;
      8'h24: letter_idx = 5'd4;   8'h2B: letter_idx = 5'd5;
      8'h34: letter_idx = 5'd6;   8'h33: letter_idx = 5'd7;
      8'h43: letter_idx = 5'd8;   8'h3B: letter_idx = 5'd9;
      8'h42: letter_idx = 5'd10;  8'h4B: letter_idx = 5'd11;
      8'h3A: letter_idx = 5'd12;  8'h31: letter_idx = 5'd13;
      8'h44: letter_idx = 5'd14;  8'h4D: letter_idx = 5'd15;
      8'h15: letter_idx = 5'd16;  8'h2D: letter_idx = 5'd17;
      8'h1B: letter_idx = 5'd18;  8'h2C: letter_idx = 5'd19;
      8'h3C: letter_idx = 5'd20;  8'h2A: letter_idx = 5'd21;
      8'h1D: letter_idx = 5'd22;  8'h22: letter_idx = 5'd23;
      8'h35: letter_idx = 5'd24;  8'h1A: letter_idx = 5'd25;
      default: is_letter = 1'b0;
    endcase

    if (extended) begin
      // Only keypad Enter produces a character among extended codes
      if (sc == SC_ENTER) begin
        ascii = ASCII_LF;
        valid = 1'b1;
      end
    end else if (is_letter) begin
      ascii = (shift_xor_caps ? 8'h41 : 8'h61) + {3'b000, letter_idx};
      valid = 1'b1;
    end else begin
      valid = 1'b1;
      // Digit row follows Shift only; Caps Lock does not apply here
      case (sc)
        8'h16:    ascii = shift_held ? 8'h21 : 8'h31;
        8'h1E:    ascii = shift_held ? 8'h40 : 8'h32;
        8'h26:    ascii = shift_held ? 8'h23 : 8'h33;
        8'h25:    ascii = shift_held ? 8'h24 : 8'h34;
        8'h2E:    ascii = shift_held ? 8'h25 : 8'h35;
        8'h36:    ascii = shift_held ? 8'h5E : 8'h36;
        8'h3D:    ascii = shift_held ? 8'h26 : 8'h37;
        8'h3E:    ascii = shift_held ? 8'h2A : 8'h38;
        8'h46:    ascii = shift_held ? 8'h28 : 8'h39;
        8'h45:    ascii = shift_held ? 8'h29 : 8'h30;
        SC_SPACE: ascii = ASCII_SPACE;
        SC_ENTER: ascii = ASCII_LF;
        SC_BKSP:  ascii = ASCII_BS;
        default:  valid = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// Purpose: PS/2 set-2 decoder: prefix FSM, Shift/Caps tracking, ASCII FIFO behind LC-3 KBSR/KBDR.
// Latency: character visible on kbdr_data/kbsr_ready one cycle after the cmd_rdy edge.
// Backpressure: none upstream; a full FIFO drops the character and sets sticky overflow.
// Ports: clk, rst_n (async active-low); cmd/cmd_rdy/error from the PS/2 receiver;
//        kbdr_rd pops the FIFO; kbsr_ready, kbdr_data, overflow, shift_held, caps_on status.
// Optional: define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeat makes until the key is released.
module ps2_kbd_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] cmd,
  input  logic       cmd_rdy,
  input  logic       error,
  input  logic       kbdr_rd,
  output logic       kbsr_ready,
  output logic [7:0] kbdr_data,
  output logic       overflow,
  output logic       shift_held,
  output logic       caps_on
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = 1;

  logic [7:0] sc;
  logic       cmd_ok;
  logic       unused_parity;

  assign sc     = bitrev8(cmd[8:1]);
  assign cmd_ok = cmd_rdy & ~error;
  // Parity is already checked by the receiver and reported on error
  assign unused_parity = cmd[0];

  // ---------------- prefix FSM ----------------
  pfx_state_t state_q, state_d;
  logic       is_make, is_break, is_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    is_make  = 1'b0;
    is_break = 1'b0;
    is_ext   = 1'b0;
    if (cmd_ok) begin
      case (state_q)
        IDLE: begin
          if (sc == SC_EXT)      state_d = EXT;
          else if (sc == SC_BRK) state_d = BRK;
          else                   is_make = 1'b1;
        end
        EXT: begin
          if (sc == SC_BRK)      state_d = EXT_BRK;
          else if (sc == SC_EXT) state_d = EXT;
          else begin
            is_make = 1'b1;
            is_ext  = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          is_break = 1'b1;
          state_d  = IDLE;
        end
        EXT_BRK: begin
          is_break = 1'b1;
          is_ext   = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------- modifiers ----------------
  logic lshift_q, rshift_q, caps_q;
  logic is_mod;

  assign is_mod     = ~is_ext & is_modifier(sc);
  assign shift_held = lshift_q | rshift_q;
  assign caps_on    = caps_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      caps_q   <= 1'b0;
    end else if (is_mod) begin
      if (is_make) begin
        if (sc == SC_LSHIFT) lshift_q <= 1'b1;
        if (sc == SC_RSHIFT) rshift_q <= 1'b1;
        if (sc == SC_CAPS)   caps_q   <= ~caps_q;
      end else if (is_break) begin
        if (sc == SC_LSHIFT) lshift_q <= 1'b0;
        if (sc == SC_RSHIFT) rshift_q <= 1'b0;
      end
    end
  end

  // ---------------- translation ----------------
  logic [7:0] char_dat;
  logic       char_vld;

  ps2_scan2ascii u_scan2ascii (
    .sc             (sc),
    .extended       (is_ext),
    .shift_xor_caps (shift_held ^ caps_q),
    .shift_held     (shift_held),
    .ascii          (char_dat),
    .valid          (char_vld)
  );

  // ---------------- typematic filter ----------------
  logic repeat_hit;
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] last_q;
  logic       last_vld_q;

  assign repeat_hit = last_vld_q && (last_q == {is_ext, sc});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= 9'd0;
      last_vld_q <= 1'b0;
    end else if (is_make && !is_mod) begin
      if (!char_vld) begin
        last_vld_q <= 1'b0;
      end else if (!repeat_hit) begin
        last_q     <= {is_ext, sc};
        last_vld_q <= 1'b1;
      end
    end else if (is_break && !is_mod) begin
      last_vld_q <= 1'b0;
    end
  end
`else
  assign repeat_hit = 1'b0;
`endif

  // ---------------- character FIFO ----------------
  logic [7:0]   mem [FIFO_DEPTH];
  logic [PTR_W:0] wr_ptr, rd_ptr, rd_nxt;
  logic [7:0]   data_q, data_d;
  logic         ovf_q;
  logic         empty, full, push_req, push, pop, drop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push_req = is_make & char_vld & ~repeat_hit;
  assign pop      = kbdr_rd & ~empty;
  // A simultaneous pop frees the slot, so a full FIFO still accepts the push
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;
  assign rd_nxt   = rd_ptr + PTR_ONE;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= char_dat;
  end

  // kbdr_data is a registered copy of the head so it can hold its last
  // value once the FIFO drains and reads as zero out of reset.
  always_comb begin
    data_d = data_q;
    if (push && empty) begin
      data_d = char_dat;
    end else if (pop) begin
      if (rd_nxt == wr_ptr) begin
        if (push) data_d = char_dat;
      end else begin
        data_d = mem[rd_nxt[PTR_W-1:0]];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      data_q <= 8'h00;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_nxt;
      data_q <= data_d;
      if (kbdr_rd)   ovf_q <= 1'b0;
      else if (drop) ovf_q <= 1'b1;
    end
  end

  assign kbsr_ready = ~empty;
  assign kbdr_data  = data_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// Purpose: directed self-checking bench for ps2_kbd_decoder (vector table plus FIFO/reset sequences).
// Latency: expects characters visible one clk after the cmd_rdy edge.
// Backpressure: exercises FIFO full/drop, push+pop while full, and reads while empty.
module tb_ps2_kbd_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [8:0] cmd;
  logic       cmd_rdy;
  logic       error;
  logic       kbdr_rd;
  logic       kbsr_ready;
  logic [7:0] kbdr_data;
  logic       overflow;
  logic       shift_held;
  logic       caps_on;

  int n_cmp = 0;
  int n_bad = 0;

  ps2_kbd_decoder #(.FIFO_DEPTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .error      (error),
    .kbdr_rd    (kbdr_rd),
    .kbsr_ready (kbsr_ready),
    .kbdr_data  (kbdr_data),
    .overflow   (overflow),
    .shift_held (shift_held),
    .caps_on    (caps_on)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] sc;
    logic       err;
    logic       exp_rdy;
    logic [7:0] exp_data;
    logic       exp_sh;
    logic       exp_caps;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [7:0] sc, input logic err, input logic rdy,
                     input logic [7:0] data, input logic sh, input logic caps);
    vec_t v;
    v.sc = sc; v.err = err; v.exp_rdy = rdy; v.exp_data = data;
    v.exp_sh = sh; v.exp_caps = caps;
    tbl.push_back(v);
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [8:0] frame(input logic [7:0] sc);
    logic [8:0] f;
    for (int i = 0; i < 8; i++) f[8-i] = sc[i];
    f[0] = ~^sc;
    return f;
  endfunction

  task automatic send(input logic [7:0] sc, input logic err, input logic rd);
    cmd     = frame(sc);
    cmd_rdy = 1'b1;
    error   = err;
    kbdr_rd = rd;
    tick();
    cmd_rdy = 1'b0;
    error   = 1'b0;
    kbdr_rd = 1'b0;
  endtask

  task automatic read();
    kbdr_rd = 1'b1;
    tick();
    kbdr_rd = 1'b0;
  endtask

  logic [7:0] seq9 [9];
  logic [7:0] exp8 [8];

  initial begin
    rst_n = 1'b0; cmd = '0; cmd_rdy = 1'b0; error = 1'b0; kbdr_rd = 1'b0;

    // sc, err, rdy, data, shift, caps
    add(8'h1C,0,1,8'h61,0,0);  add(8'h12,0,0,8'h61,1,0);
    add(8'h32,0,1,8'h42,1,0);  add(8'hF0,0,0,8'h42,1,0);
    add(8'h12,0,0,8'h42,0,0);  add(8'h21,0,1,8'h63,0,0);
    add(8'h58,0,0,8'h63,0,1);  add(8'h23,0,1,8'h44,0,1);
    add(8'h12,0,0,8'h44,1,1);  add(8'h24,0,1,8'h65,1,1);
    add(8'h16,0,1,8'h21,1,1);  add(8'hF0,0,0,8'h21,1,1);
    add(8'h12,0,0,8'h21,0,1);  add(8'h1E,0,1,8'h32,0,1);
    add(8'h58,0,0,8'h32,0,0);  add(8'hF0,0,0,8'h32,0,0);
    add(8'h58,0,0,8'h32,0,0);  add(8'hE0,0,0,8'h32,0,0);
    add(8'h5A,0,1,8'h0A,0,0);  add(8'hE0,0,0,8'h0A,0,0);
    add(8'hF0,0,0,8'h0A,0,0);  add(8'h5A,0,0,8'h0A,0,0);
    add(8'h1A,0,1,8'h7A,0,0);  add(8'hE0,0,0,8'h7A,0,0);
    add(8'h75,0,0,8'h7A,0,0);  add(8'h29,0,1,8'h20,0,0);
    add(8'hF0,1,0,8'h20,0,0);  add(8'h2B,0,1,8'h66,0,0);
    add(8'h66,0,1,8'h08,0,0);  add(8'hE0,0,0,8'h08,0,0);
    add(8'hE0,0,0,8'h08,0,0);  add(8'h5A,0,1,8'h0A,0,0);
    add(8'h45,0,1,8'h30,0,0);

    seq9 = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43};
    exp8 = '{8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h6A, 8'h6B};

    #12;
    check1("rst_ready", kbsr_ready, 1'b0);
    check8("rst_data",  kbdr_data,  8'h00);
    check1("rst_ovf",   overflow,   1'b0);
    check1("rst_shift", shift_held, 1'b0);
    check1("rst_caps",  caps_on,    1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      send(tbl[i].sc, tbl[i].err, 1'b0);
      check1($sformatf("v%0d_rdy", i),   kbsr_ready, tbl[i].exp_rdy);
      check8($sformatf("v%0d_data", i),  kbdr_data,  tbl[i].exp_data);
      check1($sformatf("v%0d_shift", i), shift_held, tbl[i].exp_sh);
      check1($sformatf("v%0d_caps", i),  caps_on,    tbl[i].exp_caps);
      if (tbl[i].exp_rdy) begin
        read();
        check1($sformatf("v%0d_popped", i), kbsr_ready, 1'b0);
      end
    end
    check1("tbl_ovf", overflow, 1'b0);

    // make then break: only one character
    send(8'h1C, 0, 0);
    send(8'hF0, 0, 0);
    send(8'h1C, 0, 0);
    check1("mb_ready", kbsr_ready, 1'b1);
    check8("mb_data",  kbdr_data,  8'h61);
    read();
    check1("mb_once", kbsr_ready, 1'b0);

    // fill to full, then one more is dropped
    for (int i = 0; i < 8; i++) send(seq9[i], 0, 0);
    check1("full_ready", kbsr_ready, 1'b1);
    check8("full_head",  kbdr_data,  8'h61);
    check1("full_noovf", overflow,   1'b0);
    send(seq9[8], 0, 0);
    check1("drop_ovf",  overflow,  1'b1);
    check8("drop_head", kbdr_data, 8'h61);
    read();
    check1("rd_clr_ovf", overflow,  1'b0);
    check8("rd_head_b",  kbdr_data, 8'h62);
    send(8'h3B, 0, 0);
    check8("refill_head", kbdr_data, 8'h62);
    // push and pop together while full
    send(8'h42, 0, 1);
    check8("pp_head", kbdr_data, 8'h63);
    check1("pp_ovf",  overflow,  1'b0);
    for (int i = 0; i < 8; i++) begin
      check1($sformatf("drain%0d_ready", i), kbsr_ready, 1'b1);
      check8($sformatf("drain%0d_data", i),  kbdr_data,  exp8[i]);
      read();
    end
    check1("drained_ready", kbsr_ready, 1'b0);
    read();
    check1("extra_rd_ready", kbsr_ready, 1'b0);
    check8("extra_rd_data",  kbdr_data,  8'h6B);
    check1("extra_rd_ovf",   overflow,   1'b0);

`ifdef PS2_TYPEMATIC_FILTER_EN
    send(8'h1C, 0, 0);
    send(8'h1C, 0, 0);
    send(8'h1C, 0, 0);
    send(8'hF0, 0, 0);
    send(8'h1C, 0, 0);
    send(8'h1C, 0, 0);
    check1("tm_ready", kbsr_ready, 1'b1);
    read();
    check1("tm_second", kbsr_ready, 1'b1);
    check8("tm_data",   kbdr_data,  8'h61);
    read();
    check1("tm_two_only", kbsr_ready, 1'b0);
`endif

    // asynchronous reset in the middle of traffic
    send(8'h58, 0, 0);
    send(8'h12, 0, 0);
    send(8'h22, 0, 0);
    send(8'h35, 0, 0);
    send(8'h1A, 0, 0);
    check1("pre_rst_ready", kbsr_ready, 1'b1);
    check1("pre_rst_caps",  caps_on,    1'b1);
    check8("pre_rst_data",  kbdr_data,  8'h78);
    #2;
    rst_n = 1'b0;
    #1;
    check1("arst_ready", kbsr_ready, 1'b0);
    check1("arst_ovf",   overflow,   1'b0);
    check1("arst_caps",  caps_on,    1'b0);
    check1("arst_shift", shift_held, 1'b0);
    check8("arst_data",  kbdr_data,  8'h00);
    tick();
    rst_n = 1'b1;
    tick();
    send(8'h1C, 0, 0);
    check1("post_rst_ready", kbsr_ready, 1'b1);
    check8("post_rst_data",  kbdr_data,  8'h61);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
